// File: rtl/sram_master_if.sv
// Host-side request/response channel of the SRAM master.
// Ports: req_* carries one access (valid/ready), rsp_* returns its result (valid/ready).
// master modport = host, slave modport = sram_master.
interface sram_master_if #(
  parameter int ADR = 8,
  parameter int DAT = 8
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [ADR-1:0] req_addr;
  logic [DAT-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DAT-1:0] rsp_rdata;
  logic           rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_master.sv
// Single-outstanding SRAM access engine: turns host requests into one-cycle SRAM strobes.
// Latency accept->rsp_valid: write 2, read 3, out-of-range 1; one request in flight at a time.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready is seen.
//
// Ports: Clk/Rst (sync, active-high); bus = host request/response channel;
// Addr/dataIn/CS/WE/RD drive the SRAM, dataOut is its read data;
// wr_cnt/rd_cnt/err_cnt count completed transactions (saturating).
module sram_master #(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  sram_master_if.slave   bus,
  output logic [ADR-1:0] Addr,
  output logic [DAT-1:0] dataIn,
  output logic           CS,
  output logic           WE,
  output logic           RD,
  input  logic [DAT-1:0] dataOut,
  output logic [15:0]    wr_cnt,
  output logic [15:0]    rd_cnt,
  output logic [15:0]    err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_RESP
  } state_t;

  // One extra bit so DPTH == 2**ADR still compares correctly.
  localparam logic [ADR:0] DEPTH_LIM = (ADR + 1)'(DPTH);
  localparam logic [15:0]  CNT_MAX   = 16'hFFFF;

  state_t state;
  state_t state_n;

  logic cs_n;
  logic we_n;
  logic rd_n;

  logic in_range;
  logic accept;
  logic rsp_hs;

  // Kind of the transaction in flight, used to pick the counter at handshake.
  logic op_we;
  logic op_err;

  assign in_range      = ({1'b0, bus.req_addr} < DEPTH_LIM);
  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  // rsp_ready outside RESP never forms a handshake.
  assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next SRAM strobes. The strobes are registered, so they
  // are computed for the state being entered: CS/WE are high exactly while
  // in WR, CS/RD exactly while in RD.
  always_comb begin
    state_n = state;
    cs_n    = 1'b0;
    we_n    = 1'b0;
    rd_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!in_range) begin
            state_n = S_RESP;
          end else if (bus.req_we) begin
            state_n = S_WR;
            cs_n    = 1'b1;
            we_n    = 1'b1;
          end else begin
            state_n = S_RD;
            cs_n    = 1'b1;
            rd_n    = 1'b1;
          end
        end
      end
      S_WR: begin
        state_n = S_RESP;
      end
      S_RD: begin
        // SRAM samples the read on the edge leaving RD; data appears in CAP.
        state_n = S_CAP;
      end
      S_CAP: begin
        state_n = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // SRAM drive, response payload and transaction bookkeeping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      CS            <= 1'b0;
      WE            <= 1'b0;
      RD            <= 1'b0;
      Addr          <= '0;
      dataIn        <= '0;
      op_we         <= 1'b0;
      op_err        <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      CS <= cs_n;
      WE <= we_n;
      RD <= rd_n;

      if (accept) begin
        op_we         <= bus.req_we;
        op_err        <= !in_range;
        bus.rsp_err   <= !in_range;
        bus.rsp_rdata <= '0;
        // Out-of-range requests never touch the SRAM pins.
        if (in_range) begin
          Addr <= bus.req_addr;
          if (bus.req_we) begin
            dataIn <= bus.req_wdata;
          end
        end
      end

      if (state == S_CAP) begin
        bus.rsp_rdata <= dataOut;
      end

      // Payload is only meaningful while rsp_valid; clear it once taken.
      if (rsp_hs) begin
        bus.rsp_rdata <= '0;
        bus.rsp_err   <= 1'b0;
      end
    end
  end

  // Saturating completion counters, bumped on the response handshake.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else if (rsp_hs) begin
      if (op_err) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end else if (op_we) begin
        if (wr_cnt != CNT_MAX) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
      end else begin
        if (rd_cnt != CNT_MAX) begin
          rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

  // Strobe sanity.
  a_we_rd_excl : assert property (@(posedge Clk) !(WE && RD));
  a_cs_state   : assert property (@(posedge Clk) disable iff (Rst)
                                  CS |-> (state == S_WR || state == S_RD));
  a_we_cs      : assert property (@(posedge Clk) (WE || RD) |-> CS);

endmodule

// File: doc/sram_master.md
SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 The block SHALL have parameter ADR, default 8, meaning the SRAM address width in bits.
REQ-002 The block SHALL have parameter DAT, default 8, meaning the SRAM data width in bits.
REQ-003 The block SHALL have parameter DPTH, default 8, meaning the number of implemented SRAM words; legal addresses are 0..DPTH-1.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: host request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: block accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADR bits: target address.
REQ-010 The block SHALL have port req_wdata, input, DAT bits: write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: host takes the response.
REQ-013 The block SHALL have port rsp_rdata, output, DAT bits: read data (0 for writes and errors).
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the address was out of range and no access was made.
REQ-015 The block SHALL have ports Addr (output, ADR bits), dataIn (output, DAT bits), CS, WE and RD (outputs, 1 bit each), all driving the SRAM.
REQ-016 The block SHALL have port dataOut, input, DAT bits: SRAM read data, updated on the edge that samples CS=1, RD=1, WE=0.
REQ-017 The block SHALL have ports wr_cnt, rd_cnt and err_cnt, outputs, 16 bits each: completed-transaction counters.

Function
REQ-018 The FSM SHALL have states IDLE, WR, RD, CAP and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; addr, we and wdata are captured on that edge.
REQ-020 On an accepted write with req_addr<DPTH, the FSM SHALL go IDLE->WR; in WR it SHALL register CS=1, WE=1, RD=0, with Addr and dataIn held stable for exactly one cycle.
REQ-021 On an accepted read with req_addr<DPTH, the FSM SHALL go IDLE->RD; in RD it SHALL register CS=1, RD=1, WE=0 for exactly one cycle. In CAP it SHALL capture dataOut into rsp_rdata.
REQ-022 On an accepted request with req_addr>=DPTH, the FSM SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0; CS SHALL stay 0.
REQ-023 CS, WE and RD SHALL be 0 in every state except WR and RD; WE and RD SHALL never both be 1.
REQ-024 Latency from the accept edge to rsp_valid=1 SHALL be 2 cycles for a write, 3 cycles for a read, and 1 cycle for an error.
REQ-025 rsp_valid SHALL be 1 only in RESP; rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, after which the FSM goes to IDLE.
REQ-026 rsp_ready=1 seen while not in RESP SHALL be ignored.
REQ-027 wr_cnt, rd_cnt and err_cnt SHALL each increment by 1 on the response handshake of their transaction type, and SHALL saturate at 16'hFFFF.
REQ-028 Back-to-back requests SHALL be accepted no more often than once per response handshake plus one IDLE cycle.

Reset
REQ-029 On an edge with Rst=1, the block SHALL set: state=IDLE, CS=WE=RD=0, Addr=0, dataIn=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and all counters 0. req_ready SHALL be 1 from the next cycle.
REQ-030 Rst SHALL override any in-flight access, including Rst in WR or RD; the pending response SHALL be discarded.

Verification
REQ-031 Write addr 3 data 8'hA5 with rsp_ready=1 -> CS=WE=1 for one cycle; rsp_valid 2 cycles after accept, rsp_err=0; wr_cnt=1.
REQ-032 Read addr 3 after REQ-031 -> RD=1 for one cycle; rsp_valid 3 cycles after accept; rsp_rdata=8'hA5; rd_cnt=1.
REQ-033 Read addr 8 with DPTH=8 -> CS never asserted; rsp_valid 1 cycle after accept; rsp_err=1; rsp_rdata=0; err_cnt=1.
REQ-034 Hold rsp_ready=0 for 5 cycles on a read -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; IDLE follows the handshake.
REQ-035 Assert Rst during RD -> next cycle CS=RD=0, rsp_valid=0, counters 0, and no response is issued.
REQ-036 Issue 65536 error requests -> err_cnt holds at 16'hFFFF.
